alu_flag_unit: RTL and testbench

64-bit integer ALU with architectural condition-flag registers (N, V, Z, C) for the single-cycle CPU datapath. It computes pass-B, add, subtract, AND, OR and XOR on two 64-bit operands. The combinational result and zero indication feed memory addressing, writeback and CBZ logic. Flags are captured on the clock edge under control of the flag-set strobes, for use by conditional branches.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_flag_unit_if.sv | 34 +++
 rtl/add64_carry.sv | 32 +++
 rtl/alu_flag_unit.sv | 110 +++++++++++
 tb/tb_alu_flag_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU / condition-flag block: the default datapath
// width and the operation-select encoding driven onto cntrl.
// Codes 001 and 111 are deliberately left out of the enum; the ALU treats
// any unlisted code as "result = 0".
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int WIDTH = 64;

   typedef enum logic [2:0] {
      PASS_B = 3'b000,
      ADD    = 3'b010,
      SUB    = 3'b011,
      AND    = 3'b100,
      OR     = 3'b101,
      XOR    = 3'b110
   } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_flag_unit_if.sv
// -----------------------------------------------------------------------------
// alu_flag_unit_if
// Bundles the operand/control inputs and the result/flag outputs of
// alu_flag_unit so a datapath (or bench) can carry them as one object.
//   master : drives A, B, cntrl, setflags, setzeroflag; observes the outputs
//   slave  : the ALU side (observes operands/controls, drives the outputs)
// -----------------------------------------------------------------------------
interface alu_flag_unit_if
   import alu_pkg::*;
#(
   parameter int W = WIDTH
);
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [2:0]   cntrl;
   logic         setflags;
   logic         setzeroflag;
   logic [W-1:0] result;
   logic         zero_alu;
   logic         negative;
   logic         overflow;
   logic         zero;
   logic         carry_out;

   modport master (
      output A, B, cntrl, setflags, setzeroflag,
      input  result, zero_alu, negative, overflow, zero, carry_out
   );

   modport slave (
      input  A, B, cntrl, setflags, setzeroflag,
      output result, zero_alu, negative, overflow, zero, carry_out
   );
endinterface : alu_flag_unit_if

// File: rtl/add64_carry.sv
// -----------------------------------------------------------------------------
// add64_carry
// WIDTH-bit adder with carry-in, reporting the carry out of the top bit and
// two's-complement signed overflow. Subtraction is done by the caller feeding
// ~B with cin = 1, so ovf is computed against the operand actually added.
// Ports:
//   a, b  : addends
//   cin   : carry into bit 0
//   sum   : a + b + cin (modulo 2^WIDTH)
//   cout  : carry out of bit WIDTH-1
//   ovf   : signed overflow (operands agree in sign, sum does not)
// -----------------------------------------------------------------------------
module add64_carry #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH:0] w_full;

   // One extra bit on the left captures the carry out of the top position.
   assign w_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign sum    = w_full[WIDTH-1:0];
   assign cout   = w_full[WIDTH];
   assign ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_full[WIDTH-1] != a[WIDTH-1]);

endmodule : add64_carry

// File: rtl/alu_flag_unit.sv
// -----------------------------------------------------------------------------
// alu_flag_unit
// Integer ALU (pass-B, add, subtract, AND, OR, XOR) with architectural
// condition flags N, V, Z, C for the single-cycle CPU datapath.
// Ports:
//   clk          : flag registers update on the rising edge
//   reset        : asynchronous, active-low; clears all flags
//   A, B         : operands
//   cntrl        : operation select (alu_pkg::alu_op_e)
//   setflags     : load N, V, Z, C at the next edge
//   setzeroflag  : load Z alone at the next edge
//   result       : combinational result
//   zero_alu     : combinational (result == 0)
//   negative, overflow, zero, carry_out : registered flags
// -----------------------------------------------------------------------------
module alu_flag_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   input  logic             setflags,
   input  logic             setzeroflag,
   output logic [WIDTH-1:0] result,
   output logic             zero_alu,
   output logic             negative,
   output logic             overflow,
   output logic             zero,
   output logic             carry_out
);

   logic             w_is_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;
   logic             w_nxt_c;
   logic             w_nxt_v;

   logic             r_n;
   logic             r_v;
   logic             r_z;
   logic             r_c;

   // Subtract reuses the adder: A + ~B + 1.
   assign w_is_sub = (cntrl == SUB);
   assign w_b_eff  = w_is_sub ? ~B : B;

   add64_carry #(.WIDTH(WIDTH)) u_add (
      .a    (A),
      .b    (w_b_eff),
      .cin  (w_is_sub),
      .sum  (w_sum),
      .cout (w_cout),
      .ovf  (w_ovf)
   );

   always_comb begin
      // NOTE: every output of this block is given a default first so no
      // path through the case leaves it unassigned (which would infer a latch).
      result  = '0;
      w_nxt_c = 1'b0;
      w_nxt_v = 1'b0;
      case (cntrl)
         PASS_B: result = B;
         ADD, SUB: begin
            result  = w_sum;
            w_nxt_c = w_cout;
            w_nxt_v = w_ovf;
         end
         AND:     result = A & B;
         OR:      result = A | B;
         XOR:     result = A ^ B;
         default: result = '0;
      endcase
   end

   assign zero_alu = (result == '0);

   // N, V, C follow setflags only; Z also loads on setzeroflag (CBZ-style ops).
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         r_n <= 1'b0;
         r_v <= 1'b0;
         r_z <= 1'b0;
         r_c <= 1'b0;
      end else begin
         if (setflags) begin
            r_n <= result[WIDTH-1];
            r_v <= w_nxt_v;
            r_c <= w_nxt_c;
         end
         if (setflags || setzeroflag) begin
            r_z <= zero_alu;
         end
      end
   end

   assign negative  = r_n;
   assign overflow  = r_v;
   assign zero      = r_z;
   assign carry_out = r_c;

endmodule : alu_flag_unit

// File: tb/tb_alu_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_flag_unit
// Directed plus randomized stimulus for alu_flag_unit, checked against an
// arithmetic reference model of the ALU and flag registers.
// -----------------------------------------------------------------------------
module tb_alu_flag_unit;
   import alu_pkg::*;

   logic clk;
   logic reset;

   int checks;
   int failures;

   // Reference flag state.
   logic m_n, m_v, m_z, m_c;

   alu_flag_unit_if bus ();

   alu_flag_unit #(.WIDTH(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .A           (bus.A),
      .B           (bus.B),
      .cntrl       (bus.cntrl),
      .setflags    (bus.setflags),
      .setzeroflag (bus.setzeroflag),
      .result      (bus.result),
      .zero_alu    (bus.zero_alu),
      .negative    (bus.negative),
      .overflow    (bus.overflow),
      .zero        (bus.zero),
      .carry_out   (bus.carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural ALU: written from the operation table with plain arithmetic.
   task automatic ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                          output logic [63:0] res, output logic n, output logic v,
                          output logic c);
      logic [64:0] wide;
      res = 64'd0;
      v   = 1'b0;
      c   = 1'b0;
      case (op)
         3'b000: res = b;
         3'b010: begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[63:0];
            c    = wide[64];
            v    = (a[63] == b[63]) && (res[63] != a[63]);
         end
         3'b011: begin
            res = a - b;
            c   = (a >= b);
            v   = (a[63] != b[63]) && (res[63] != a[63]);
         end
         3'b100: res = a & b;
         3'b101: res = a | b;
         3'b110: res = a ^ b;
         default: res = 64'd0;
      endcase
      n = res[63];
   endtask

   task automatic check_flags(input string tag);
      check({tag, " N"}, {63'd0, bus.negative},  {63'd0, m_n});
      check({tag, " V"}, {63'd0, bus.overflow},  {63'd0, m_v});
      check({tag, " Z"}, {63'd0, bus.zero},      {63'd0, m_z});
      check({tag, " C"}, {63'd0, bus.carry_out}, {63'd0, m_c});
   endtask

   // Apply one operation between edges, check the combinational outputs,
   // take one edge, update the model, then check the registered flags.
   task automatic step(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                       input logic sf, input logic sz, input string tag);
      logic [63:0] res;
      logic        n, v, c;
      bus.A           = a;
      bus.B           = b;
      bus.cntrl       = op;
      bus.setflags    = sf;
      bus.setzeroflag = sz;
      #1;
      ref_alu(a, b, op, res, n, v, c);
      check({tag, " result"},   bus.result, res);
      check({tag, " zero_alu"}, {63'd0, bus.zero_alu}, {63'd0, (res == 64'd0)});
      @(posedge clk);
      if (reset) begin
         if (sf) begin
            m_n = n;
            m_v = v;
            m_c = c;
         end
         if (sf || sz) m_z = (res == 64'd0);
      end
      #1;
      check_flags(tag);
   endtask

   function automatic logic [63:0] rand_operand();
      logic [63:0] specials [6];
      specials[0] = 64'd0;
      specials[1] = 64'd1;
      specials[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      specials[3] = 64'h7FFF_FFFF_FFFF_FFFF;
      specials[4] = 64'h8000_0000_0000_0000;
      specials[5] = 64'h8000_0000_0000_0001;
      if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [63:0] ra, rb;
      logic [2:0]  rop;
      logic        rsf, rsz;

      checks   = 0;
      failures = 0;
      m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0;

      bus.A           = 64'd0;
      bus.B           = 64'd0;
      bus.cntrl       = 3'b010;
      bus.setflags    = 1'b1;
      bus.setzeroflag = 1'b0;
      reset           = 1'b1;

      // Reset asserted between edges clears flags without a clock.
      #2 reset = 1'b0;
      #1;
      check_flags("reset async");
      // Strobe high across edges while in reset: flags stay clear.
      @(posedge clk); @(posedge clk); #1;
      check_flags("reset held");
      // Release between edges: still clear until an edge loads them.
      #2 reset = 1'b1;
      #1;
      check_flags("reset release");
      @(negedge clk);

      step(64'd0, 64'd0, 3'b010, 1'b1, 1'b0, "post reset add0");

      // Add with signed overflow.
      step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 1'b0, "add ovf");
      // Add with carry wrap to zero.
      step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 1'b0, "add wrap");
      // Subtract equal, then with borrow.
      step(64'd5, 64'd5, 3'b011, 1'b1, 1'b0, "sub eq");
      step(64'd3, 64'd5, 3'b011, 1'b1, 1'b0, "sub borrow");
      check("sub borrow literal", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
      step(64'h8000_0000_0000_0000, 64'd1, 3'b011, 1'b1, 1'b0, "sub ovf");

      // Logic and pass-B.
      step(64'hF0F0, 64'h0FF0, 3'b100, 1'b1, 1'b0, "and");
      check("and literal", bus.result, 64'h00F0);
      step(64'hF0F0, 64'h0FF0, 3'b101, 1'b1, 1'b0, "or");
      check("or literal", bus.result, 64'hFFF0);
      step(64'hF0F0, 64'h0FF0, 3'b110, 1'b1, 1'b0, "xor");
      check("xor literal", bus.result, 64'hFF00);
      step(64'hF0F0, 64'h0FF0, 3'b000, 1'b1, 1'b0, "pass");
      check("pass literal", bus.result, 64'h0FF0);
      step(64'h1234, 64'h5678, 3'b001, 1'b1, 1'b0, "code 001");
      step(64'h1234, 64'h5678, 3'b111, 1'b1, 1'b0, "code 111");

      // Strobe gating: preset N=1 V=1 Z=0 C=0, then load Z alone, then hold.
      step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 1'b0, "gate preset");
      step(64'd0, 64'd0, 3'b000, 1'b0, 1'b1, "gate z only");
      check("gate z=1",  {63'd0, bus.zero},     64'd1);
      check("gate n=1",  {63'd0, bus.negative}, 64'd1);
      step(64'd9, 64'd7, 3'b000, 1'b0, 1'b0, "gate hold");
      step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b0, 1'b0, "gate hold add");
      step(64'd0, 64'd1, 3'b011, 1'b1, 1'b1, "both strobes");

      // Reset mid-operation with a strobe pending.
      bus.setflags = 1'b1;
      #2 reset = 1'b0;
      m_n = 1'b0; m_v = 1'b0; m_z = 1'b0; m_c = 1'b0;
      #1;
      check_flags("mid reset");
      @(posedge clk); #1;
      check_flags("mid reset edge");
      reset = 1'b1;
      @(negedge clk);

      // Randomized operations and strobes against the model.
      for (int i = 0; i < 300; i++) begin
         ra  = rand_operand();
         rb  = rand_operand();
         rop = 3'($urandom_range(7));
         rsf = 1'($urandom_range(1));
         rsz = 1'($urandom_range(1));
         step(ra, rb, rop, rsf, rsz, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_flag_unit
